local_memory_arbiter: RTL

Round-robin arbiter sharing one local-memory secondary port (address/byteSelect/enable/writeEnable/dataWrite/dataRead/busy) between up to four bus requesters, e.g. the Wishbone slave, the JTAG/debug bridge and a DMA engine. Sits between those requesters and the secondary interface of the SRAM memory interface. Grants are registered, held for up to HOLD_LIMIT back-to-back transactions while others wait, and then rotated.

---
 rtl/local_memory_arbiter_pkg.sv | 12 +
 rtl/local_memory_arbiter_if.sv | 41 ++++
 rtl/local_memory_arbiter_rr_priority_select.sv | 32 +++
 rtl/local_memory_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/local_memory_arbiter_pkg.sv
// local_memory_arbiter_pkg: shared constants for the local memory arbiter.
// State encodings, requester index type and the idle read value.
package local_memory_arbiter_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [31:0] IDLE_READ = 32'hFFFF_FFFF;

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/local_memory_arbiter_if.sv
// local_memory_arbiter_if: requester-side and memory-side bus bundle.
// slave = arbiter view, master = requesters plus memory view.
interface local_memory_arbiter_if #(
    parameter int ADDRESS_SIZE = 24,
    parameter int REQUESTERS   = 2
);
    logic [REQUESTERS*ADDRESS_SIZE-1:0] reqAddress;
    logic [REQUESTERS*4-1:0]            reqByteSelect;
    logic [REQUESTERS-1:0]              reqEnable;
    logic [REQUESTERS-1:0]              reqWriteEnable;
    logic [REQUESTERS*32-1:0]           reqDataWrite;
    logic [REQUESTERS*32-1:0]           reqDataRead;
    logic [REQUESTERS-1:0]              reqBusy;

    logic [ADDRESS_SIZE-1:0]            memAddress;
    logic [3:0]                         memByteSelect;
    logic                               memEnable;
    logic                               memWriteEnable;
    logic [31:0]                        memDataWrite;
    logic [31:0]                        memDataRead;
    logic                               memBusy;

    modport slave (
        input  reqAddress, reqByteSelect, reqEnable,
        input  reqWriteEnable, reqDataWrite,
        input  memDataRead, memBusy,
        output reqDataRead, reqBusy,
        output memAddress, memByteSelect, memEnable,
        output memWriteEnable, memDataWrite
    );

    modport master (
        output reqAddress, reqByteSelect, reqEnable,
        output reqWriteEnable, reqDataWrite,
        output memDataRead, memBusy,
        input  reqDataRead, reqBusy,
        input  memAddress, memByteSelect, memEnable,
        input  memWriteEnable, memDataWrite
    );

endinterface

// File: rtl/local_memory_arbiter_rr_priority_select.sv
// local_memory_arbiter_rr_priority_select: combinational round-robin picker.
// Searches last+1, last+2, ... modulo REQUESTERS for the first request.
module local_memory_arbiter_rr_priority_select
    import local_memory_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 2
) (
    input  logic [REQUESTERS-1:0] req_i,
    input  req_idx_t              last_i,
    output req_idx_t              winner_o,
    output logic                  valid_o
);

    // First set request after the last winner takes the grant
    always_comb begin
        int                    idx;
        logic [REQUESTERS-1:0] sh;
        idx      = 0;
        sh       = '0;
        winner_o = '0;
        valid_o  = 1'b0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            idx = (int'(last_i) + k) % REQUESTERS;
            sh  = req_i >> idx;
            if (!valid_o && sh[0]) begin
                valid_o  = 1'b1;
                winner_o = req_idx_t'(idx);
            end
        end
    end

endmodule

// File: rtl/local_memory_arbiter.sv
// local_memory_arbiter: round-robin sharing of one local memory port.
// Grants are registered and held up to HOLD_LIMIT completions under contention.
module local_memory_arbiter
    import local_memory_arbiter_pkg::*;
#(
    parameter int ADDRESS_SIZE = 24,
    parameter int REQUESTERS   = 2,
    parameter int HOLD_LIMIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    local_memory_arbiter_if.slave bus,
    output logic                  grantValid,
    output req_idx_t              grantIndex
);

    localparam int HW = $clog2(HOLD_LIMIT + 1);

    logic [0:0]            state_q, state_d;
    req_idx_t              grant_q, grant_d;
    req_idx_t              last_q, last_d;
    logic [HW-1:0]         hold_q, hold_d;
    req_idx_t              pick;
    logic                  pick_valid;
    logic                  active;
    logic                  gnt_en;
    logic                  others;
    logic [REQUESTERS-1:0] gnt_mask;
    int                    gi;

    assign gi       = int'(grant_q);
    assign active   = (state_q == ST_ACTIVE);
    assign gnt_mask = REQUESTERS'(1) << grant_q;
    assign gnt_en   = |(bus.reqEnable & gnt_mask);
    assign others   = |(bus.reqEnable & ~gnt_mask);

    local_memory_arbiter_rr_priority_select #(
        .REQUESTERS (REQUESTERS)
    ) u_rr_priority_select (
        .req_i    (bus.reqEnable),
        .last_i   (last_q),
        .winner_o (pick),
        .valid_o  (pick_valid)
    );

    // Grant, release and rotation decisions
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_q;
        if (state_q == ST_IDLE) begin
            if (pick_valid) begin
                state_d = ST_ACTIVE;
                grant_d = pick;
                last_d  = pick;
                hold_d  = '0;
            end
        end else if (!gnt_en) begin
            state_d = ST_IDLE;
        end else if (!bus.memBusy) begin
            // a saturated count still rotates once a contender shows up
            if ((int'(hold_q) + 1 >= HOLD_LIMIT) && others) begin
                state_d = ST_IDLE;
            end else if (int'(hold_q) < HOLD_LIMIT) begin
                hold_d = hold_q + HW'(1);
            end
        end
    end

    // Arbiter registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= req_idx_t'(REQUESTERS - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Forward the granted requester to the memory port, quiet when idle
    always_comb begin
        bus.memAddress     = '0;
        bus.memByteSelect  = '0;
        bus.memEnable      = 1'b0;
        bus.memWriteEnable = 1'b0;
        bus.memDataWrite   = '0;
        if (active) begin
            bus.memAddress     = ADDRESS_SIZE'(bus.reqAddress >> (gi * ADDRESS_SIZE));
            bus.memByteSelect  = 4'(bus.reqByteSelect >> (gi * 4));
            bus.memEnable      = gnt_en;
            bus.memWriteEnable = |(bus.reqWriteEnable & gnt_mask);
            bus.memDataWrite   = 32'(bus.reqDataWrite >> (gi * 32));
        end
    end

    for (genvar i = 0; i < REQUESTERS; i++) begin : g_req
        logic mine;
        assign mine = active && (grant_q == req_idx_t'(i));
        assign bus.reqBusy[i] = bus.reqEnable[i] && !(mine && !bus.memBusy);
        assign bus.reqDataRead[i*32 +: 32] = mine ? bus.memDataRead : IDLE_READ;
    end

    assign grantValid = active;
    assign grantIndex = grant_q;

endmodule
